// File: rtl/seal_log_fifo_pkg.sv
// rtl/seal_log_fifo_pkg.sv - shared types, field indices and seal byte selection for the seal logger
package seal_log_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_LATCH = 2'd2
  } seal_state_e;

  localparam int CI_CRC_RESET  = 0;
  localparam int CI_COMMIT     = 1;
  localparam int CI_SID_LSB    = 2;
  localparam int CI_SID_MSB    = 9;
  localparam int CI_CLR_STATUS = 10;

  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  localparam logic [1:0] RD_VALUE   = 2'd0;
  localparam logic [1:0] RD_SIDMONO = 2'd1;
  localparam logic [1:0] RD_CRC     = 2'd2;

  typedef struct packed {
    logic [31:0] value;
    logic [7:0]  sid;
    logic [31:0] mono;
    logic [15:0] crc;
  } seal_rec_t;

  localparam int REC_W = $bits(seal_rec_t);

  // Byte stream is LSB-first {prev_crc, sensor, value, mono}; without chaining the prev_crc bytes are skipped.
  function automatic logic [7:0] seal_byte(input logic [3:0] idx, input logic chain,
                                           input logic [15:0] prev, input logic [7:0] sensor,
                                           input logic [31:0] value, input logic [31:0] mono);
    logic [87:0] flat;
    logic [3:0]  pos;
    flat = {mono, value, sensor, prev};
    pos  = chain ? idx : idx + 4'd2;
    flat = flat >> {pos, 3'b000};
    return flat[7:0];
  endfunction

endpackage

// File: rtl/seal_log_fifo_if.sv
// rtl/seal_log_fifo_if.sv - peripheral bus and CRC engine signals of the seal logger
interface seal_log_fifo_if;
  logic [7:0]  crc_byte;
  logic        crc_feed;
  logic        crc_busy;
  logic [15:0] crc_value;
  logic        crc_init;
  logic        data_wr;
  logic [31:0] data_in;
  logic        data_rd;
  logic [31:0] data_out;
  logic        ctrl_wr;
  logic [10:0] ctrl_in;
  logic [31:0] ctrl_out;
  logic [7:0]  session_ctr_in;

  modport slave (
    output crc_byte, crc_feed, crc_init, data_out, ctrl_out,
    input  crc_busy, crc_value, data_wr, data_in, data_rd, ctrl_wr, ctrl_in, session_ctr_in
  );

  modport master (
    input  crc_byte, crc_feed, crc_init, data_out, ctrl_out,
    output crc_busy, crc_value, data_wr, data_in, data_rd, ctrl_wr, ctrl_in, session_ctr_in
  );
endinterface

// File: rtl/seal_log_fifo_rec_fifo.sv
// rtl/seal_log_fifo_rec_fifo.sv - sealed record storage with occupancy count
module seal_rec_fifo
  import seal_log_fifo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_push,
  input  logic      i_pop,
  input  seal_rec_t i_rec,
  output seal_rec_t o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic      o_full,
  output logic      o_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [REC_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;

  // Pop+push while full writes the slot being vacated, which covers both eviction and read-then-push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_rec;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
endmodule

// File: rtl/seal_log_fifo.sv
// rtl/seal_log_fifo.sv - CRC16-sealed commit logger with record FIFO and 3-word readback
module seal_log_fifo
  import seal_log_fifo_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter bit OVERWRITE = 1'b0,
  parameter bit CHAIN     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  seal_log_fifo_if.slave bus
);
  localparam logic [3:0] LAST_IDX = CHAIN ? 4'd10 : 4'd8;

  seal_state_e r_state, w_next;
  logic [31:0] r_value, r_cur_mono, r_mono;
  logic [7:0]  r_sensor, r_session, r_drop;
  logic [15:0] r_prev_crc;
  logic [3:0]  r_byte_idx;
  logic        r_byte_sent, r_gap, r_sid_locked, r_ovf;
  logic [1:0]  r_rd_seq;

  logic        w_busy, w_commit, w_clr, w_feed, w_init, w_byte_done;
  logic        w_latch, w_rd, w_rd_pop, w_space, w_push, w_evict, w_drop;
  logic        w_full, w_empty;
  logic [$clog2(DEPTH):0] w_count;
  logic [7:0]  w_sid;
  seal_rec_t   w_rec, w_head;

  assign w_busy   = (r_state != ST_IDLE);
  assign w_commit = bus.ctrl_wr & bus.ctrl_in[CI_COMMIT] & (r_state == ST_IDLE);
  assign w_clr    = bus.ctrl_wr & bus.ctrl_in[CI_CLR_STATUS];

  always_comb begin
    w_next      = r_state;
    w_feed      = 1'b0;
    w_init      = 1'b0;
    w_byte_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.ctrl_wr && (bus.ctrl_in[CI_COMMIT] || bus.ctrl_in[CI_CRC_RESET])) w_init = 1'b1;
        if (w_commit) w_next = ST_FEED;
      end
      ST_FEED: begin
        // The cycle after a feed is skipped because the engine only raises busy one cycle late.
        w_feed = !r_byte_sent && !bus.crc_busy;
        if (r_byte_sent && !r_gap && !bus.crc_busy) begin
          w_byte_done = 1'b1;
          if (r_byte_idx == LAST_IDX) w_next = ST_LATCH;
        end
      end
      ST_LATCH: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  assign bus.crc_feed = w_feed;
  assign bus.crc_init = w_init;
  assign bus.crc_byte = w_feed ? seal_byte(r_byte_idx, CHAIN, r_prev_crc, r_sensor, r_value, r_cur_mono)
                               : 8'h00;

  assign w_latch  = (r_state == ST_LATCH);
  assign w_rd     = bus.data_rd & !w_empty;
  assign w_rd_pop = w_rd & (r_rd_seq == RD_CRC);
  assign w_space  = !w_full | w_rd_pop;
  assign w_push   = w_latch & (w_space | OVERWRITE);
  assign w_evict  = w_latch & !w_space & OVERWRITE;
  assign w_drop   = w_latch & !w_space;
  assign w_sid    = r_sid_locked ? r_session : bus.session_ctr_in;
  assign w_rec    = '{value: r_value, sid: w_sid, mono: r_cur_mono, crc: bus.crc_value};

  seal_rec_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_rd_pop | w_evict),
    .i_rec   (w_rec),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_value      <= '0;
      r_cur_mono   <= '0;
      r_mono       <= '0;
      r_sensor     <= '0;
      r_session    <= '0;
      r_drop       <= '0;
      r_prev_crc   <= '0;
      r_byte_idx   <= '0;
      r_byte_sent  <= 1'b0;
      r_gap        <= 1'b0;
      r_sid_locked <= 1'b0;
      r_ovf        <= 1'b0;
      r_rd_seq     <= RD_VALUE;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE) begin
        if (bus.data_wr) r_value <= bus.data_in;
        if (w_commit) begin
          r_sensor    <= bus.ctrl_in[CI_SID_MSB:CI_SID_LSB];
          r_cur_mono  <= r_mono;
          r_byte_idx  <= '0;
          r_byte_sent <= 1'b0;
          r_gap       <= 1'b0;
        end
      end
      if (r_state == ST_FEED) begin
        if (w_feed) begin
          r_byte_sent <= 1'b1;
          r_gap       <= 1'b1;
        end else if (r_gap) begin
          r_gap <= 1'b0;
        end
        if (w_byte_done) begin
          r_byte_sent <= 1'b0;
          r_byte_idx  <= r_byte_idx + 4'd1;
        end
      end
      if (w_latch) begin
        r_mono       <= r_mono + 32'd1;
        r_sid_locked <= 1'b1;
        r_session    <= w_sid;
        if (w_push) r_prev_crc <= bus.crc_value;
        if (w_drop) begin
          r_ovf <= 1'b1;
          if (r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
        end
      end
      if (w_evict) r_rd_seq <= RD_VALUE;
      else if (w_rd) r_rd_seq <= (r_rd_seq == RD_CRC) ? RD_VALUE : r_rd_seq + 2'd1;
      if (w_clr) begin
        r_ovf  <= 1'b0;
        r_drop <= '0;
      end
    end
  end

  always_comb begin
    bus.data_out = 32'h0;
    if (!w_empty) begin
      case (r_rd_seq)
        RD_VALUE:   bus.data_out = w_head.value;
        RD_SIDMONO: bus.data_out = {w_head.sid, w_head.mono[23:0]};
        default:    bus.data_out = {w_head.mono[31:24], w_head.crc, 8'h00};
      endcase
    end
  end

  assign bus.ctrl_out = {8'h00, 8'(w_count), r_drop, 3'b000, r_ovf, w_full, w_empty, !w_busy, w_busy};
endmodule

// File: tb/tb_seal_log_fifo.sv
// tb/tb_seal_log_fifo.sv - directed self-checking bench for seal_log_fifo
module tb_seal_log_fifo;
  import seal_log_fifo_pkg::*;

  typedef struct packed {
    logic [31:0] v;
    logic [31:0] m;
    logic [15:0] c;
  } erec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic        sel = 1'b0;
  logic        t_data_wr = 1'b0, t_data_rd = 1'b0, t_ctrl_wr = 1'b0;
  logic [31:0] t_data_in = '0;
  logic [10:0] t_ctrl_in = '0;
  logic [7:0]  t_session = 8'hA5;

  seal_log_fifo_if b0();
  seal_log_fifo_if b1();

  seal_log_fifo #(.DEPTH(4), .OVERWRITE(1'b0), .CHAIN(1'b1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  seal_log_fifo #(.DEPTH(4), .OVERWRITE(1'b1), .CHAIN(1'b1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

  assign b0.data_wr = t_data_wr & !sel;
  assign b1.data_wr = t_data_wr & sel;
  assign b0.data_rd = t_data_rd & !sel;
  assign b1.data_rd = t_data_rd & sel;
  assign b0.ctrl_wr = t_ctrl_wr & !sel;
  assign b1.ctrl_wr = t_ctrl_wr & sel;
  assign b0.data_in = t_data_in;
  assign b1.data_in = t_data_in;
  assign b0.ctrl_in = t_ctrl_in;
  assign b1.ctrl_in = t_ctrl_in;
  assign b0.session_ctr_in = t_session;
  assign b1.session_ctr_in = t_session;

  wire [31:0] ctrl_out = sel ? b1.ctrl_out : b0.ctrl_out;
  wire [31:0] data_out = sel ? b1.data_out : b0.data_out;
  wire        feed     = sel ? b1.crc_feed : b0.crc_feed;

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  function automatic logic [15:0] seal_crc(input logic [15:0] prev, input logic [7:0] sensor,
                                           input logic [31:0] val, input logic [31:0] mono);
    logic [15:0] c;
    c = 16'hFFFF;
    c = crc_upd(c, prev[7:0]);
    c = crc_upd(c, prev[15:8]);
    c = crc_upd(c, sensor);
    for (int i = 0; i < 4; i++) c = crc_upd(c, 8'(val >> (8 * i)));
    for (int i = 0; i < 4; i++) c = crc_upd(c, 8'(mono >> (8 * i)));
    return c;
  endfunction

  // CRC engine stand-ins: busy for two cycles after each fed byte
  logic [15:0] e0_crc = 16'hFFFF, e1_crc = 16'hFFFF;
  logic [1:0]  e0_cnt = 2'd0, e1_cnt = 2'd0;
  always @(posedge clk) begin
    if (b0.crc_init) e0_crc <= CRC_INIT;
    else if (b0.crc_feed) e0_crc <= crc_upd(e0_crc, b0.crc_byte);
    if (b0.crc_feed) e0_cnt <= 2'd2;
    else if (e0_cnt != 2'd0) e0_cnt <= e0_cnt - 2'd1;
  end
  always @(posedge clk) begin
    if (b1.crc_init) e1_crc <= CRC_INIT;
    else if (b1.crc_feed) e1_crc <= crc_upd(e1_crc, b1.crc_byte);
    if (b1.crc_feed) e1_cnt <= 2'd2;
    else if (e1_cnt != 2'd0) e1_cnt <= e1_cnt - 2'd1;
  end
  assign b0.crc_busy  = (e0_cnt != 2'd0);
  assign b1.crc_busy  = (e1_cnt != 2'd0);
  assign b0.crc_value = e0_crc;
  assign b1.crc_value = e1_crc;

  erec_t q0[$], q1[$];
  logic [15:0] prev0 = 16'h0, prev1 = 16'h0;
  logic [31:0] mono0 = 32'h0, mono1 = 32'h0;
  logic [7:0]  sid0 = 8'hA5, sid1 = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic wr_data(input logic [31:0] v);
    t_data_in = v; t_data_wr = 1'b1;
    @(negedge clk);
    t_data_wr = 1'b0;
  endtask

  task automatic wr_ctrl(input logic [10:0] c);
    t_ctrl_in = c; t_ctrl_wr = 1'b1;
    @(negedge clk);
    t_ctrl_wr = 1'b0; t_ctrl_in = '0;
  endtask

  task automatic rd(output logic [31:0] v);
    v = data_out; t_data_rd = 1'b1;
    @(negedge clk);
    t_data_rd = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (ctrl_out[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", {31'b0, ctrl_out[0]}, 32'h0);
  endtask

  task automatic model0(input logic [31:0] val, input logic [7:0] sensor);
    logic [15:0] c;
    c = seal_crc(prev0, sensor, val, mono0);
    if (q0.size() < 4) begin
      q0.push_back('{v: val, m: mono0, c: c});
      prev0 = c;
    end
    mono0 = mono0 + 32'd1;
  endtask

  task automatic model1(input logic [31:0] val, input logic [7:0] sensor);
    logic [15:0] c;
    c = seal_crc(prev1, sensor, val, mono1);
    if (q1.size() == 4) void'(q1.pop_front());
    q1.push_back('{v: val, m: mono1, c: c});
    prev1 = c;
    mono1 = mono1 + 32'd1;
  endtask

  task automatic commit(input logic [31:0] val, input logic [7:0] sensor);
    wr_data(val);
    wr_ctrl({1'b0, sensor, 2'b10});
    wait_idle();
    if (sel) model1(val, sensor);
    else model0(val, sensor);
  endtask

  task automatic chk_rec(input erec_t e, input logic [7:0] sid);
    logic [31:0] w0, w1, w2;
    rd(w0); rd(w1); rd(w2);
    chk("rec_value", w0, e.v);
    chk("rec_sidmono", w1, {sid, e.m[23:0]});
    chk("rec_crc", w2, {e.m[31:24], e.c, 8'h00});
  endtask

  initial begin
    logic [31:0] w;
    int nf, n;
    erec_t e;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ctrl0", b0.ctrl_out, 32'h6);
    chk("reset_ctrl1", b1.ctrl_out, 32'h6);
    chk("reset_data0", b0.data_out, 32'h0);
    chk("reset_crc_out", {22'b0, b0.crc_init, b0.crc_feed, b0.crc_byte}, 32'h0);

    // single commit then chained second commit, session locks on the first
    commit(32'hDEADBEEF, 8'h12);
    chk("one_entry_ctrl", ctrl_out, 32'h0001_0002);
    t_session = 8'h3C;
    commit(32'h0123_4567, 8'h34);
    chk("two_entry_ctrl", ctrl_out, 32'h0002_0002);
    chk_rec(q0.pop_front(), sid0);
    chk_rec(q0.pop_front(), sid0);
    chk("drained_ctrl", ctrl_out, 32'h6);
    chk("empty_data", data_out, 32'h0);
    rd(w);
    chk("empty_rd_ctrl", ctrl_out, 32'h6);

    // drop policy: fifth commit lost, its mono leaves a gap
    for (int k = 0; k < 5; k++) commit(32'h100 + k, 8'h40 + 8'(k));
    chk("drop_ctrl", ctrl_out, 32'h0004_011A);
    chk_rec(q0.pop_front(), sid0);
    commit(32'h200, 8'h50);
    chk("drop_refill_ctrl", ctrl_out, 32'h0004_011A);
    while (q0.size() > 0) chk_rec(q0.pop_front(), sid0);
    chk("gap_mono", mono0, 32'd8);
    chk("drop_drained_ctrl", ctrl_out, 32'h0000_0116);
    wr_ctrl(11'h400);
    chk("clr_status0", ctrl_out, 32'h6);

    // overwrite policy with a read in progress
    sel = 1'b1;
    sid1 = t_session;
    for (int k = 0; k < 4; k++) commit(32'h300 + k, 8'h60 + 8'(k));
    chk("ovw_full_ctrl", ctrl_out, 32'h0004_000A);
    rd(w);
    chk("ovw_head0", w, 32'h300);
    commit(32'h304, 8'h64);
    chk("ovw_evict_ctrl", ctrl_out, 32'h0004_011A);
    rd(w);
    chk("ovw_rdseq_reset", w, 32'h301);
    rd(w);
    chk("ovw_word1", w, {sid1, 24'd1});
    wr_ctrl(11'h400);
    chk("clr_status1", ctrl_out, 32'h0004_000A);

    // third read lands on the LATCH cycle of a commit into a full FIFO
    wr_data(32'h305);
    wr_ctrl({1'b0, 8'h65, 2'b10});
    nf = 0; n = 0;
    while (n < 300) begin
      if (feed) nf++;
      if (nf == 11) break;
      @(negedge clk);
      n++;
    end
    chk("feed_count", nf, 11);
    repeat (4) @(negedge clk);
    e = q1.pop_front();
    rd(w);
    chk("same_cycle_word2", w, {e.m[31:24], e.c, 8'h00});
    model1(32'h305, 8'h65);
    wait_idle();
    chk("same_cycle_ctrl", ctrl_out, 32'h0004_000A);
    chk_rec(q1.pop_front(), sid1);

    // commands during FEED are ignored
    sel = 1'b0;
    wr_data(32'h55AA_55AA);
    wr_ctrl({1'b0, 8'h70, 2'b10});
    @(negedge clk);
    wr_data(32'hCAFE_F00D);
    wr_ctrl({1'b0, 8'h71, 2'b10});
    chk("feed_ctrl", ctrl_out, 32'h5);
    wait_idle();
    model0(32'h55AA_55AA, 8'h70);
    chk("feed_ignore_ctrl", ctrl_out, 32'h0001_0002);
    chk_rec(q0.pop_front(), sid0);

    // reset in the middle of a seal
    wr_data(32'h0BAD_F00D);
    wr_ctrl({1'b0, 8'h72, 2'b10});
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midfeed_reset_ctrl", ctrl_out, 32'h6);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("after_reset_ctrl0", b0.ctrl_out, 32'h6);
    chk("after_reset_ctrl1", b1.ctrl_out, 32'h6);
    q0.delete(); prev0 = 16'h0; mono0 = 32'h0;
    t_session = 8'h77; sid0 = 8'h77;
    commit(32'h1122_3344, 8'h81);
    chk("post_reset_ctrl", ctrl_out, 32'h0001_0002);
    chk_rec(q0.pop_front(), sid0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
